// File: rtl/video_frame_sequencer_if.sv
// Pixel-beat stream between the raster sequencer and the downstream consumer.
// The sequencer drives coordinates and markers; the consumer answers with tready.
interface video_frame_sequencer_if #(
    parameter int W_BITS = 11,
    parameter int H_BITS = 11
);
    logic              tvalid;
    logic              tready;
    logic [W_BITS-1:0] x_coord;
    logic [H_BITS-1:0] y_coord;
    logic              sof;
    logic              eol;
    logic              eof;

    modport master (
        output tvalid, x_coord, y_coord, sof, eol, eof,
        input  tready
    );

    modport slave (
        input  tvalid, x_coord, y_coord, sof, eol, eof,
        output tready
    );
endinterface

// File: rtl/video_frame_sequencer.sv
// Raster-scan frame sequencer: walks x/y over a latched geometry with ready/valid
// backpressure, inserting programmable line and frame blanking gaps.
module video_frame_sequencer #(
    parameter int W_BITS     = 11,
    parameter int H_BITS     = 11,
    parameter int BLANK_BITS = 8
) (
    input  logic                    pixclk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    continuous,
    input  logic [W_BITS-1:0]       cfg_width,
    input  logic [H_BITS-1:0]       cfg_height,
    input  logic [BLANK_BITS-1:0]   cfg_hblank,
    input  logic [BLANK_BITS-1:0]   cfg_vblank,
    video_frame_sequencer_if.master pix,
    output logic                    busy,
    output logic                    frame_done,
    output logic [15:0]             frame_count,
    output logic                    cfg_err
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACTIVE = 2'd1;
    localparam logic [1:0] HBLANK = 2'd2;
    localparam logic [1:0] VBLANK = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [W_BITS-1:0]     x_q, x_d, width_q, width_d;
    logic [H_BITS-1:0]     y_q, y_d, height_q, height_d;
    logic [BLANK_BITS-1:0] hblank_q, hblank_d, vblank_q, vblank_d, blank_q, blank_d;
    logic                  cont_q, cont_d, stop_pend_q, stop_pend_d;
    logic                  tvalid_q, tvalid_d, busy_q, busy_d;
    logic                  frame_done_q, frame_done_d, cfg_err_q, cfg_err_d;
    logic [15:0]           frame_count_q, frame_count_d;

    logic accept, last_x, last_y, keep_streaming;

    assign accept = tvalid_q && pix.tready;
    assign last_x = (x_q == width_q - W_BITS'(1));
    assign last_y = (y_q == height_q - H_BITS'(1));
    // A stop arriving in the very cycle of the decision still ends the stream.
    assign keep_streaming = cont_q && !(stop_pend_q || stop);

    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        width_d       = width_q;
        height_d      = height_q;
        hblank_d      = hblank_q;
        vblank_d      = vblank_q;
        blank_d       = blank_q;
        cont_d        = cont_q;
        stop_pend_d   = stop_pend_q || (stop && state_q != IDLE);
        frame_done_d  = 1'b0;
        cfg_err_d     = 1'b0;
        frame_count_d = frame_count_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_width == '0 || cfg_height == '0) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        width_d     = cfg_width;
                        height_d    = cfg_height;
                        hblank_d    = cfg_hblank;
                        vblank_d    = cfg_vblank;
                        cont_d      = continuous;
                        stop_pend_d = 1'b0;
                        x_d         = '0;
                        y_d         = '0;
                        state_d     = ACTIVE;
                    end
                end
            end
            ACTIVE: begin
                if (accept) begin
                    if (!last_x) begin
                        x_d = x_q + W_BITS'(1);
                    end else if (!last_y) begin
                        x_d = '0;
                        y_d = y_q + H_BITS'(1);
                        if (hblank_q != '0) begin
                            state_d = HBLANK;
                            blank_d = hblank_q - BLANK_BITS'(1);
                        end
                    end else begin
                        x_d           = '0;
                        y_d           = '0;
                        frame_done_d  = 1'b1;
                        frame_count_d = frame_count_q + 16'd1;
                        if (vblank_q != '0) begin
                            state_d = VBLANK;
                            blank_d = vblank_q - BLANK_BITS'(1);
                        end else begin
                            state_d = keep_streaming ? ACTIVE : IDLE;
                        end
                    end
                end
            end
            HBLANK: begin
                if (blank_q == '0) state_d = ACTIVE;
                else               blank_d = blank_q - BLANK_BITS'(1);
            end
            VBLANK: begin
                if (blank_q == '0) state_d = keep_streaming ? ACTIVE : IDLE;
                else               blank_d = blank_q - BLANK_BITS'(1);
            end
            default: state_d = IDLE;
        endcase

        // Output flags are registered from the next state so they align with it.
        tvalid_d = (state_d == ACTIVE);
        busy_d   = (state_d != IDLE);
    end

    always_ff @(posedge pixclk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            x_q           <= '0;
            y_q           <= '0;
            width_q       <= '0;
            height_q      <= '0;
            hblank_q      <= '0;
            vblank_q      <= '0;
            blank_q       <= '0;
            cont_q        <= 1'b0;
            stop_pend_q   <= 1'b0;
            tvalid_q      <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            cfg_err_q     <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            width_q       <= width_d;
            height_q      <= height_d;
            hblank_q      <= hblank_d;
            vblank_q      <= vblank_d;
            blank_q       <= blank_d;
            cont_q        <= cont_d;
            stop_pend_q   <= stop_pend_d;
            tvalid_q      <= tvalid_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            cfg_err_q     <= cfg_err_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign pix.tvalid  = tvalid_q;
    assign pix.x_coord = x_q;
    assign pix.y_coord = y_q;
    assign pix.sof     = tvalid_q && (x_q == '0) && (y_q == '0);
    assign pix.eol     = tvalid_q && last_x;
    assign pix.eof     = tvalid_q && last_x && last_y;

    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign frame_count = frame_count_q;
    assign cfg_err     = cfg_err_q;
endmodule

// File: tb/tb_video_frame_sequencer.sv
// Self-checking bench for video_frame_sequencer: start-response table, scenario
// table and randomized streams checked against an arithmetic raster model.
module tb_video_frame_sequencer;
    localparam int WB = 11;
    localparam int HB = 11;
    localparam int BB = 8;

    logic          pixclk = 1'b0;
    logic          reset, start, stop, continuous, tready;
    logic [WB-1:0] cfg_width;
    logic [HB-1:0] cfg_height;
    logic [BB-1:0] cfg_hblank, cfg_vblank;
    logic          busy, frame_done, cfg_err;
    logic [15:0]   frame_count;

    int tests  = 0;
    int fails  = 0;
    int exp_fc = 0;

    video_frame_sequencer_if #(.W_BITS(WB), .H_BITS(HB)) pix ();
    assign pix.tready = tready;

    video_frame_sequencer #(.W_BITS(WB), .H_BITS(HB), .BLANK_BITS(BB)) dut (
        .pixclk     (pixclk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .continuous (continuous),
        .cfg_width  (cfg_width),
        .cfg_height (cfg_height),
        .cfg_hblank (cfg_hblank),
        .cfg_vblank (cfg_vblank),
        .pix        (pix),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_count(frame_count),
        .cfg_err    (cfg_err)
    );

    always #5 pixclk = ~pixclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int w;
        int h;
        bit exp_err;
        bit exp_busy;
    } start_vec_t;

    typedef struct {
        int w, h, hb, vb;
        bit cont;
        int stop_beat;
        int mode;
        int ign_cyc;
        int exp_frames;
    } stream_vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge pixclk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        exp_fc = 0;
        step();
    endtask

    // Streams one start command and checks every cycle against the raster rules:
    // beat k of the stream sits at x = k mod W, y = (k div W) mod H.
    task automatic stream_check(input stream_vec_t v);
        int wh, total, acc, gap, tail, pat, ex, ey;
        bit want, fd_exp, prev_stall, done;
        logic [WB-1:0] px;
        logic [HB-1:0] py;
        logic [3:0] pat_bits;
        pat_bits = 4'b1001;
        wh = v.w * v.h;
        total = v.exp_frames * wh;
        acc = 0; gap = 0; tail = -1; pat = 0;
        want = 1'b1; fd_exp = 1'b0; prev_stall = 1'b0; done = 1'b0;
        px = '0; py = '0;

        cfg_width  = WB'(v.w);
        cfg_height = HB'(v.h);
        cfg_hblank = BB'(v.hb);
        cfg_vblank = BB'(v.vb);
        continuous = v.cont;
        tready     = 1'b0;
        start      = 1'b1;
        step();
        start = 1'b0;

        for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
            chk("no_cfg_err", cfg_err, 0);
            chk("frame_done", frame_done, fd_exp);
            if (tail >= 0) begin
                chk("tail_tvalid", pix.tvalid, 0);
                if (tail == 0) begin
                    chk("busy_end", busy, 0);
                    done = 1'b1;
                end else begin
                    chk("busy_vblank", busy, 1);
                    tail--;
                end
            end else begin
                chk("busy", busy, 1);
                if (prev_stall) begin
                    chk("stall_tvalid", pix.tvalid, 1);
                    chk("stall_x", pix.x_coord, px);
                    chk("stall_y", pix.y_coord, py);
                end else if (gap > 0) begin
                    chk("blank_tvalid", pix.tvalid, 0);
                    gap--;
                end else if (want) begin
                    chk("beat_tvalid", pix.tvalid, 1);
                    want = 1'b0;
                end
            end
            if (!done) begin
                fd_exp = 1'b0;
                stop   = 1'b0;
                start  = 1'b0;
                if (cyc == v.ign_cyc) begin
                    start      = 1'b1;
                    cfg_width  = WB'(v.w + 2);
                    cfg_height = HB'(v.h + 1);
                end
                if (v.mode == 0)      tready = pat_bits[pat % 4];
                else if (v.mode == 1) tready = ($urandom_range(0, 3) != 0);
                else                  tready = 1'b1;
                pat++;
                prev_stall = pix.tvalid && !tready;
                px = pix.x_coord;
                py = pix.y_coord;
                if (pix.tvalid && tready) begin
                    ex = acc % v.w;
                    ey = (acc / v.w) % v.h;
                    chk("beat_x", pix.x_coord, ex);
                    chk("beat_y", pix.y_coord, ey);
                    chk("sof", pix.sof, (ex == 0 && ey == 0));
                    chk("eol", pix.eol, (ex == v.w - 1));
                    chk("eof", pix.eof, (ex == v.w - 1 && ey == v.h - 1));
                    acc++;
                    if (acc == v.stop_beat) stop = 1'b1;
                    if (acc == total) begin
                        tail = v.vb; fd_exp = 1'b1; exp_fc++;
                    end else if (acc % wh == 0) begin
                        gap = v.vb; want = 1'b1; fd_exp = 1'b1; exp_fc++;
                    end else if (ex == v.w - 1) begin
                        gap = v.hb; want = 1'b1;
                    end else begin
                        want = 1'b1;
                    end
                end
                step();
            end
        end
        chk("stream_finished", done, 1);
        chk("beats_accepted", acc, total);
        chk("frame_count", frame_count, exp_fc & 16'hFFFF);
        start = 1'b0; stop = 1'b0; tready = 1'b0;
        step();
    endtask

    start_vec_t  svec [6];
    stream_vec_t tvec [7];
    stream_vec_t rv;

    initial begin
        svec[0] = '{0,    3,    1'b1, 1'b0};
        svec[1] = '{4,    0,    1'b1, 1'b0};
        svec[2] = '{0,    0,    1'b1, 1'b0};
        svec[3] = '{1,    1,    1'b0, 1'b1};
        svec[4] = '{2047, 2047, 1'b0, 1'b1};
        svec[5] = '{5,    1,    1'b0, 1'b1};

        //          w  h  hb vb cont stop mode ign frames
        tvec[0] = '{4, 3, 2, 3, 1'b0, 0,  2,  -1, 1};
        tvec[1] = '{3, 2, 0, 0, 1'b0, 0,  0,  -1, 1};
        tvec[2] = '{2, 2, 0, 1, 1'b1, 10, 2,  -1, 3};
        tvec[3] = '{2, 2, 0, 1, 1'b1, 4,  2,  -1, 1};
        tvec[4] = '{4, 2, 1, 0, 1'b0, 0,  2,  2,  1};
        tvec[5] = '{3, 3, 2, 0, 1'b1, 20, 1,  -1, 3};
        tvec[6] = '{1, 1, 0, 0, 1'b1, 3,  2,  -1, 3};

        start = 1'b0; stop = 1'b0; continuous = 1'b0; tready = 1'b0;
        cfg_width = '0; cfg_height = '0; cfg_hblank = '0; cfg_vblank = '0;
        reset = 1'b1;
        step();
        step();
        chk("rst_tvalid", pix.tvalid, 0);
        chk("rst_x", pix.x_coord, 0);
        chk("rst_y", pix.y_coord, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_markers", {pix.sof, pix.eol, pix.eof}, 0);
        reset = 1'b0;
        step();

        for (int i = 0; i < 6; i++) begin
            apply_reset();
            cfg_width  = WB'(svec[i].w);
            cfg_height = HB'(svec[i].h);
            cfg_hblank = '0; cfg_vblank = '0; continuous = 1'b0; tready = 1'b0;
            start = 1'b1;
            step();
            start = 1'b0;
            chk("start_cfg_err", cfg_err, svec[i].exp_err);
            chk("start_busy", busy, svec[i].exp_busy);
            chk("start_tvalid", pix.tvalid, svec[i].exp_busy);
            chk("start_sof", pix.sof, svec[i].exp_busy);
            chk("start_xy", {pix.x_coord, pix.y_coord}, 0);
            step();
            chk("cfg_err_pulse_end", cfg_err, 0);
            chk("hold_busy", busy, svec[i].exp_busy);
            chk("hold_tvalid", pix.tvalid, svec[i].exp_busy);
            $display("[TB] start vector %0d w=%0d h=%0d done", i, svec[i].w, svec[i].h);
        end
        apply_reset();

        for (int i = 0; i < 7; i++) begin
            stream_check(tvec[i]);
            $display("[TB] scenario %0d w=%0d h=%0d frames=%0d done", i, tvec[i].w, tvec[i].h, tvec[i].exp_frames);
        end

        for (int i = 0; i < 10; i++) begin
            rv.w = $urandom_range(1, 5);
            rv.h = $urandom_range(1, 4);
            rv.hb = $urandom_range(0, 3);
            rv.vb = $urandom_range(0, 3);
            rv.cont = $urandom_range(0, 1);
            rv.mode = $urandom_range(0, 2);
            rv.ign_cyc = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 10) : -1;
            if (rv.cont) begin
                rv.stop_beat = $urandom_range(1, 3 * rv.w * rv.h);
                rv.exp_frames = (rv.stop_beat + rv.w * rv.h - 1) / (rv.w * rv.h);
            end else begin
                rv.stop_beat = $urandom_range(0, rv.w * rv.h);
                rv.exp_frames = 1;
            end
            stream_check(rv);
            $display("[TB] random %0d w=%0d h=%0d hb=%0d vb=%0d frames=%0d done",
                     i, rv.w, rv.h, rv.hb, rv.vb, rv.exp_frames);
        end

        // Reset in the middle of a frame, with a nonzero frame count behind it.
        cfg_width = WB'(3); cfg_height = HB'(3); cfg_hblank = '0; cfg_vblank = '0;
        continuous = 1'b0; tready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("pre_reset_x", pix.x_coord, 1);
        chk("pre_reset_y", pix.y_coord, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_tvalid", pix.tvalid, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_xy", {pix.x_coord, pix.y_coord}, 0);
        chk("async_rst_frame_count", frame_count, 0);
        step();
        reset = 1'b0;
        exp_fc = 0;
        tready = 1'b0;
        step();
        chk("post_reset_idle", busy, 0);
        rv = '{3, 3, 1, 1, 1'b0, 0, 2, -1, 1};
        stream_check(rv);
        $display("[TB] reset mid-frame then fresh frame done");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/video_frame_sequencer.md
# video_frame_sequencer

Raster-scan controller for the video pixel path. On a start command it latches a frame geometry and drives pixel-beat timing for one frame or a continuous stream: valid, x/y coordinates and start/end markers, with programmable horizontal and vertical blanking. It honours a ready/valid handshake from the downstream pixel consumer. It sits ahead of the pixel datapath and sequences reads from the frame buffer or the test-pattern source, so that coordinates line up with the per-pixel checkers downstream.

## Interface
Parameters:
- W_BITS, 11, width of cfg_width/x_coord (max 2047)
- H_BITS, 11, width of cfg_height/y_coord
- BLANK_BITS, 8, width of blanking counters

Ports:
- pixclk  in  1  sole clock; all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- start  in  1  single-cycle frame start request
- stop  in  1  single-cycle request to end streaming after the current frame
- continuous  in  1  sampled with start; 1 = repeat frames until stop
- cfg_width  in  W_BITS  pixels per line, sampled with start
- cfg_height  in  H_BITS  lines per frame, sampled with start
- cfg_hblank  in  BLANK_BITS  idle cycles between lines
- cfg_vblank  in  BLANK_BITS  idle cycles after each frame
- tready  in  1  downstream accepts the beat
- tvalid  out  1  beat valid
- x_coord  out  W_BITS  current pixel column
- y_coord  out  H_BITS  current line
- sof  out  1  tvalid && x=0 && y=0
- eol  out  1  tvalid && x=width-1
- eof  out  1  eol && y=height-1
- busy  out  1  state ≠ IDLE
- frame_done  out  1  one-cycle pulse after the last beat of a frame is accepted
- frame_count  out  16  completed frames since reset; wraps 0xFFFF→0
- cfg_err  out  1  one-cycle pulse when start is rejected

## Operation
- States: IDLE, ACTIVE, HBLANK, VBLANK.
- IDLE + start:
  - if cfg_width=0 or cfg_height=0: pulse cfg_err and stay IDLE.
  - otherwise latch all cfg_* and continuous, clear stop_pending, set x=y=0, go ACTIVE.
- start outside IDLE is ignored. Latched config never changes mid-stream.
- ACTIVE: tvalid=1. A beat is accepted when tvalid && tready.
  - Accepted, x<width-1: x+1.
  - Accepted, x=width-1, y<height-1: x=0, y+1. Go HBLANK if hblank>0, else stay ACTIVE (back-to-back lines).
  - Accepted, x=width-1, y=height-1: frame_done pulse, frame_count+1, x=y=0. Go VBLANK if vblank>0, else take the end-of-frame decision immediately.
- HBLANK/VBLANK: tvalid=0 for exactly cfg_hblank/cfg_vblank cycles, then continue.
- End-of-frame decision: continuous && !stop_pending → ACTIVE (new frame). Otherwise → IDLE.
- stop in any non-IDLE state sets stop_pending. A frame is never truncated. stop in IDLE has no effect.
- Coordinates are arithmetic modulo nothing: the counters never exceed the latched width-1/height-1.

## Timing
- All outputs registered except sof/eol/eof, which are decoded from registered state.
- Reset values: tvalid=0, x_coord=0, y_coord=0, busy=0, frame_done=0, cfg_err=0, frame_count=0, state IDLE, stop_pending=0.
- start sampled at edge N → busy=1 and tvalid=1 with x=y=0 from edge N+1. cfg_err is asserted in cycle N+1.
- Backpressure: while tvalid && !tready, tvalid, x_coord, y_coord and the markers hold stable. tvalid never drops without acceptance.
- Throughput with tready=1: W·H beats per frame, plus H-1 hblank gaps of cfg_hblank cycles and one cfg_vblank gap.
- frame_done is high in the cycle after the final beat is accepted; frame_count updates on that same edge.
- stop in the same cycle as the last beat's acceptance counts as pending for that frame: the block goes IDLE.
- Reset asserted mid-frame clears everything asynchronously. After release, the block is IDLE until the next start.

## Test plan
- Single frame, W=4, H=3, hblank=2, vblank=3, tready=1, continuous=0:
  - 12 beats, with tvalid low for 2 cycles after beats 4 and 8.
  - sof on beat 1; eol on beats 4/8/12; eof on beat 12.
  - frame_done one cycle later; frame_count=1; busy falls after 3 vblank cycles.
- Backpressure: W=3, H=2, tready toggled 1,0,0,1,… → each beat held stable while tready=0; 6 accepted beats in coordinate order; no beat lost or duplicated.
- Config error: start with cfg_width=0 → cfg_err pulse 1 cycle later, busy=0, tvalid never asserted. Same check with cfg_height=0.
- Continuous with stop: W=2, H=2, hblank=0, vblank=1, continuous=1; stop mid-frame 3 → frames 3 completes fully, frame_count=3, then IDLE. With hblank=0, lines run back-to-back.
- Reset mid-frame: assert reset at x=1, y=1 → tvalid, busy and coordinates 0 in the same cycle, frame_count=0. A fresh start then produces a full frame from (0,0).
- Ignored start: pulse start during ACTIVE with a different cfg_width → geometry unchanged, no cfg_err pulse.
